game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 9: points that end a game; legal range 1..15.
REQ-002 SHALL have parameter SERVE_TICKS, default 120: refresh ticks spent in SERVE; legal range 1..255, 120 = 2 s at 60 Hz.
REQ-003 SHALL have port clk  in  1  system clock, sole clock domain.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  asynchronous start/serve button, active-high.
REQ-006 SHALL have port refresh_tick  in  1  one-cycle pulse per frame, at start of vertical retrace.
REQ-007 SHALL have port hit  in  1  right paddle struck ball, level.
REQ-008 SHALL have port hit2  in  1  left paddle struck ball, level.
REQ-009 SHALL have port miss  in  1  ball outside playfield, level; stays high until ball recentred.
REQ-010 SHALL have port miss_right  in  1  qualifies miss: 1 = ball exited right edge, 0 = left edge.
REQ-011 SHALL have port gra_still  out  1  holds ball at centre with serve velocity.
REQ-012 SHALL have port score_l, score_r  out  4 each  left/right player scores.
REQ-013 SHALL have port game_over  out  1  high only in OVER.
REQ-014 SHALL have port winner  out  2  01 = left, 10 = right, 00 = none.
REQ-015 SHALL have port state  out  2  current FSM state encoding.

Function
REQ-016 SHALL pass start through a two-flop synchronizer, then a rising-edge detector; start_p = one-cycle pulse.
REQ-017 SHALL implement states IDLE=00, SERVE=01, PLAY=10, OVER=11; all outputs registered.
REQ-018 IDLE: gra_still=1; score_l, score_r, winner = 0; start_p -> SERVE.
REQ-019 SERVE: gra_still=1; 8-bit tick counter loaded 0 on entry, +1 per refresh_tick; counter == SERVE_TICKS-1 on a tick -> PLAY.
REQ-020 PLAY: gra_still=0; miss=1 -> increment left score when miss_right=1, right score when 0.
REQ-021 PLAY: incremented score == WIN_SCORE -> OVER with winner set; otherwise -> SERVE.
REQ-022 Latency: miss in cycle N -> score, state and gra_still=1 updated in cycle N+1.
REQ-023 miss SHALL be acted on only in PLAY; a lingering miss level in SERVE/OVER/IDLE is ignored, so each miss scores exactly once.
REQ-024 hit/hit2 with miss in the same cycle: miss wins.
REQ-025 hit/hit2 SHALL never change state or score.
REQ-026 start_p SHALL be ignored in SERVE and PLAY.
REQ-027 OVER: gra_still=1, game_over=1; scores and winner held; start_p -> IDLE, clearing scores and winner next cycle.
REQ-028 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.

Reset
REQ-029 reset_n low SHALL asynchronously force:
- state=IDLE, gra_still=1
- scores, winner, game_over, tick counter and synchronizer flops = 0
REQ-030 Reset asserted mid-game SHALL abandon the game; after release the block waits in IDLE for a fresh start_p.

Configuration
REQ-031 With macro GAME_CTRL_RALLY_EN defined:
- SHALL add output rally_cnt  out  8
- rally_cnt counts rising edges of (hit|hit2) in PLAY, saturating at 255
- rally_cnt = 0 on reset and on entry to SERVE
REQ-032 Without GAME_CTRL_RALLY_EN, the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-033 SHALL put the following in shared package game_pkg:
- state encoding type
- score width constant (4)
- winner codes
REQ-034 SHALL place synchronizer plus edge detector in sub-module btn_edge (ports clk, reset_n, btn_in, pulse_out).

Verification
REQ-035 Reset then start pulse: state IDLE->SERVE; after 120 refresh_ticks, state=PLAY and gra_still=0.
REQ-036 miss=1, miss_right=1 held 5 cycles in PLAY: score_l=1 exactly, state=SERVE and gra_still=1 one cycle after miss rises.
REQ-037 WIN_SCORE=3, three right-edge misses: state=OVER, game_over=1, winner=01, score_l=3; start pulse -> IDLE with scores 0.
REQ-038 hit and miss (miss_right=0) in same PLAY cycle: score_r increments, state=SERVE; with GAME_CTRL_RALLY_EN, rally_cnt clears.
REQ-039 reset_n low mid-PLAY with score_r=4: outputs zero/IDLE immediately, without waiting for a clock edge.
REQ-040 start toggled during PLAY: no state or score change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game controller: state encoding,
// score width and winner codes.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam int SCORE_W = 4;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a
// rising-edge detector producing a one-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic pulse_out
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_out = sync2_q & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Pong-style game controller: IDLE/SERVE/PLAY/OVER sequencing and scoring.
// Define GAME_CTRL_RALLY_EN to add the rally_cnt hit counter output.
module game_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 120
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               refresh_tick,
  input  logic               hit,
  input  logic               hit2,
  input  logic               miss,
  input  logic               miss_right,
  output logic               gra_still,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [1:0]         state
`ifdef GAME_CTRL_RALLY_EN
  ,
  output logic [7:0]         rally_cnt
`endif
);

  localparam logic [SCORE_W-1:0] WIN_Q     = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         TICK_LAST = 8'(SERVE_TICKS - 1);

  state_t             state_q, state_d;
  logic [7:0]         tick_q, tick_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [1:0]         winner_q, winner_d;
  logic               gra_still_q;
  logic               game_over_q;
  logic               start_p;
  logic [SCORE_W-1:0] score_l_inc;
  logic [SCORE_W-1:0] score_r_inc;

  btn_edge u_btn_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_in    (start),
    .pulse_out (start_p)
  );

  assign score_l_inc = score_l_q + SCORE_W'(1);
  assign score_r_inc = score_r_q + SCORE_W'(1);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    case (state_q)
      ST_IDLE: begin
        score_l_d = '0;
        score_r_d = '0;
        winner_d  = WIN_NONE;
        tick_d    = '0;
        if (start_p) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (refresh_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = ST_PLAY;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        tick_d = '0;
        // miss outranks any simultaneous paddle hit; hits never affect scoring
        if (miss) begin
          state_d = ST_SERVE;
          if (miss_right) begin
            score_l_d = score_l_inc;
            if (score_l_inc == WIN_Q) begin
              state_d  = ST_OVER;
              winner_d = WIN_LEFT;
            end
          end else begin
            score_r_d = score_r_inc;
            if (score_r_inc == WIN_Q) begin
              state_d  = ST_OVER;
              winner_d = WIN_RIGHT;
            end
          end
        end
      end
      ST_OVER: begin
        if (start_p) begin
          state_d   = ST_IDLE;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = WIN_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= WIN_NONE;
      gra_still_q <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      gra_still_q <= (state_d != ST_PLAY);
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign gra_still = gra_still_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign state     = state_q;

`ifdef GAME_CTRL_RALLY_EN
  logic [7:0] rally_q;
  logic       hit_prev_q;
  logic       hit_any;

  assign hit_any = hit | hit2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rally_q    <= '0;
      hit_prev_q <= 1'b0;
    end else begin
      hit_prev_q <= hit_any;
      if (state_d == ST_SERVE && state_q != ST_SERVE) begin
        rally_q <= '0;
      end else if (state_q == ST_PLAY && !miss && hit_any && !hit_prev_q
                   && rally_q != 8'hFF) begin
        rally_q <= rally_q + 8'd1;
      end
    end
  end

  assign rally_cnt = rally_q;
`else
  logic unused_hits;
  assign unused_hits = hit ^ hit2;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a rule-level game model.
module tb_game_ctrl;

  localparam int WIN = 5;
  localparam int STK = 120;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       refresh_tick = 1'b0;
  logic       hit = 1'b0;
  logic       hit2 = 1'b0;
  logic       miss = 1'b0;
  logic       miss_right = 1'b0;
  logic       gra_still;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic [1:0] winner;
  logic [1:0] state;
`ifdef GAME_CTRL_RALLY_EN
  logic [7:0] rally_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // model: phase 0 idle, 1 serving, 2 rally in play, 3 game finished
  int m_phase, m_ticks, m_l, m_r, m_win;
  int d1, d2, d3;
  int m_rally, m_hprev;

  game_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(STK)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .refresh_tick (refresh_tick),
    .hit          (hit),
    .hit2         (hit2),
    .miss         (miss),
    .miss_right   (miss_right),
    .gra_still    (gra_still),
    .score_l      (score_l),
    .score_r      (score_r),
    .game_over    (game_over),
    .winner       (winner),
    .state        (state)
`ifdef GAME_CTRL_RALLY_EN
    ,
    .rally_cnt    (rally_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_l = 0; m_r = 0; m_win = 0;
    d1 = 0; d2 = 0; d3 = 0;
    m_rally = 0; m_hprev = 0;
  endtask

  // Apply the game rules to the inputs about to be sampled at the next edge.
  task automatic model_step();
    int sp, old_phase, hany;
    sp = (d2 == 1 && d3 == 0) ? 1 : 0;
    old_phase = m_phase;
    hany = (hit || hit2) ? 1 : 0;
    case (m_phase)
      0: if (sp == 1) begin m_phase = 1; m_ticks = 0; end
      1: if (refresh_tick) begin
           m_ticks++;
           if (m_ticks == STK) m_phase = 2;
         end
      2: if (miss) begin
           if (miss_right) m_l++; else m_r++;
           if (m_l == WIN) begin m_phase = 3; m_win = 1; end
           else if (m_r == WIN) begin m_phase = 3; m_win = 2; end
           else begin m_phase = 1; m_ticks = 0; end
         end
      default: if (sp == 1) begin m_phase = 0; m_l = 0; m_r = 0; m_win = 0; end
    endcase
    if (old_phase == 2 && !miss && hany == 1 && m_hprev == 0 && m_rally < 255) m_rally++;
    if (m_phase == 1 && old_phase != 1) m_rally = 0;
    m_hprev = hany;
    d3 = d2; d2 = d1; d1 = start ? 1 : 0;
  endtask

  task automatic check_outputs();
    check("state", int'(state), m_phase);
    check("gra_still", int'(gra_still), (m_phase != 2) ? 1 : 0);
    check("score_l", int'(score_l), m_l);
    check("score_r", int'(score_r), m_r);
    check("winner", int'(winner), m_win);
    check("game_over", int'(game_over), (m_phase == 3) ? 1 : 0);
`ifdef GAME_CTRL_RALLY_EN
    check("rally_cnt", int'(rally_cnt), m_rally);
`endif
  endtask

  task automatic cycle(input logic s, input logic tk, input logic h, input logic h2,
                       input logic m, input logic mr);
    @(negedge clk);
    start = s; refresh_tick = tk; hit = h; hit2 = h2; miss = m; miss_right = mr;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic press_start();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Must be called right after entering SERVE; checks the exact tick boundary.
  task automatic serve_to_play();
    repeat (STK - 1) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("serve_hold", int'(state), 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("serve_end", int'(state), 2);
    check("gra_play", int'(gra_still), 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start = 1'b0; refresh_tick = 1'b0; hit = 1'b0; hit2 = 1'b0; miss = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_state", int'(state), 0);
    check("rst_gra", int'(gra_still), 1);
    check("rst_score_l", int'(score_l), 0);
    check("rst_score_r", int'(score_r), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_over", int'(game_over), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int mhold;
    logic st, mr_r;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check("por_state", int'(state), 0);
    check("por_gra", int'(gra_still), 1);
    check("por_scores", int'({score_l, score_r}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_wait", int'(state), 0);

    press_start();
    check("to_serve", int'(state), 1);
    serve_to_play();

    // lingering miss scores exactly once
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("miss_score", int'(score_l), 1);
    check("miss_serve", int'(state), 1);
    check("miss_gra", int'(gra_still), 1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("miss_once", int'(score_l), 1);

    // start toggling and hits in PLAY change nothing
    serve_to_play();
    for (int i = 0; i < 12; i++) cycle(i[1], 1'b0, i[0], i[2], 1'b0, 1'b0);
    check("start_in_play", int'(state), 2);
    check("hits_no_score", int'({score_l, score_r}), 16);

    // hit and miss together: miss wins
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("hitmiss_r", int'(score_r), 1);
    check("hitmiss_st", int'(state), 1);

    // left player wins
    for (int p = 0; p < WIN - 1; p++) begin
      serve_to_play();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check("over_state", int'(state), 3);
    check("over_flag", int'(game_over), 1);
    check("over_winner", int'(winner), 1);
    check("over_score", int'(score_l), WIN);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("over_held", int'(score_l), WIN);
    press_start();
    check("restart_idle", int'(state), 0);
    check("restart_clear", int'({score_l, score_r, winner}), 0);

    // reset mid-PLAY with score_r = 4
    press_start();
    for (int p = 0; p < 4; p++) begin
      serve_to_play();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("pre_rst_r", int'(score_r), 4);
    serve_to_play();
    async_reset();
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_idle", int'(state), 0);

    // randomized run against the model
    mhold = 0; st = 1'b0; mr_r = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 7) == 0) st = ~st;
      if (mhold > 0) mhold--;
      else if ($urandom_range(0, 24) == 0) begin
        mhold = $urandom_range(1, 6);
        mr_r = 1'($urandom_range(0, 1));
      end
      cycle(st, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), (mhold > 0), mr_r);
      if ($urandom_range(0, 4999) == 0) begin
        async_reset();
        st = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
